// File: rtl/reg_file_reader_if.sv
// Request and read-data handshake bundle for the register-file burst reader.
// The master side issues requests and consumes words; the slave side is the reader.
interface reg_file_reader_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic          rd_last;

    modport master (
        output req_valid, req_addr, req_len, rd_ready,
        input  req_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready,
        output req_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/reg_file_reader.sv
// Burst read sequencer: takes (start address, beat count) and streams register
// words out one per beat on a valid/ready port, wrapping addresses modulo 2**AW.
module reg_file_reader #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(2**AW)*W-1:0]    regs,
    reg_file_reader_if.slave        bus,
    output logic                    busy
);
    localparam int N = 2 ** AW;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_last_q, rd_last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  word [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_word
        assign word[gi] = regs[gi*W +: W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = STREAM;
            STREAM:  if (bus.rd_ready && rd_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        busy          = (state_q != IDLE);
        // rd_valid is exactly "in STREAM": entered with a word loaded, left when the last one goes.
        bus.rd_valid  = (state_q == STREAM);
        bus.rd_data   = rd_data_q;
        bus.rd_last   = rd_last_q;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_last_d = rd_last_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    rd_data_d = word[bus.req_addr];
                    addr_d    = bus.req_addr + 1'b1;
                    cnt_d     = bus.req_len;
                    rd_last_d = (bus.req_len == '0);
                end
            end
            STREAM: begin
                if (bus.rd_ready) begin
                    if (rd_last_q) begin
                        rd_last_d = 1'b0;
                    end else begin
                        rd_data_d = word[addr_q];
                        addr_d    = addr_q + 1'b1;
                        cnt_d     = cnt_q - 1'b1;
                        rd_last_d = (cnt_q == AW'(1));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
            rd_last_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_last_q <= rd_last_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader: a burst-level model queues expected words
// on request acceptance, and a monitor checks every presented word against it.
module tb_reg_file_reader;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int N  = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] regs;
    logic           busy;

    reg_file_reader_if #(.W(W), .AW(AW)) bus_if ();

    reg_file_reader #(.W(W), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .regs (regs),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] got_q[$];
    int           checks = 0;
    int           errors = 0;
    int           hs_count = 0;
    bit           m_active = 1'b0;
    int           m_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] reg_at(input int k);
        return regs[(k % N)*W +: W];
    endfunction

    // Burst-level reference: an accepted request expands into its full list of words.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_rem    = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (bus_if.req_valid) begin
                m_active = 1'b1;
                m_rem    = int'(bus_if.req_len) + 1;
                for (int i = 0; i < m_rem; i++)
                    exp_q.push_back('{data: reg_at(int'(bus_if.req_addr) + i), last: (i == m_rem - 1)});
            end
        end else if (bus_if.rd_ready) begin
            m_rem--;
            if (m_rem == 0) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("req_ready", {31'd0, bus_if.req_ready}, {31'd0, !m_active});
            check("busy", {31'd0, busy}, {31'd0, m_active});
            check("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, m_active});
            if (bus_if.rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got word %0h, expected none at %0t", bus_if.rd_data, $time);
                end else begin
                    check("rd_data", {24'd0, bus_if.rd_data}, {24'd0, exp_q[0].data});
                    check("rd_last", {31'd0, bus_if.rd_last}, {31'd0, exp_q[0].last});
                    if (bus_if.rd_ready) begin
                        got_q.push_back(bus_if.rd_data);
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end else begin
                check("rd_last_idle", {31'd0, bus_if.rd_last}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, m_active}, 32'd0);
    endtask

    task automatic request(input int addr, input int len);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = AW'(addr);
        bus_if.req_len   = AW'(len);
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic check_seq(input string name, input logic [W-1:0] exp[$]);
        check({name, "_count"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check(name, {24'd0, got_q[i]}, {24'd0, exp[i]});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_valid"}, {31'd0, bus_if.rd_valid}, 32'd0);
        check({name, "_rd_last"}, {31'd0, bus_if.rd_last}, 32'd0);
        check({name, "_rd_data"}, {24'd0, bus_if.rd_data}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_req_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_seq[$];
        logic         bp_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int           hs0;
        int           n;

        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_len   = '0;
        bus_if.rd_ready  = 1'b0;
        regs             = '0;

        // Reset held with random inputs toggling
        for (int c = 0; c < 3; c++) begin
            bus_if.req_valid = 1'($urandom);
            bus_if.req_addr  = AW'($urandom);
            bus_if.req_len   = AW'($urandom);
            bus_if.rd_ready  = 1'($urandom);
            regs             = {$urandom(), $urandom()};
            @(negedge clk);
            check_reset_outputs("reset");
        end
        bus_if.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Single beat
        regs[5*W +: W] = 8'hA5;
        bus_if.rd_ready = 1'b1;
        got_q.delete();
        request(5, 0);
        wait_idle();
        tick();
        exp_seq = '{8'hA5};
        check_seq("single", exp_seq);

        // Wrapped full burst
        for (int k = 0; k < N; k++) regs[k*W +: W] = W'(8'h10 + k);
        got_q.delete();
        request(6, 7);
        wait_idle();
        exp_seq = '{8'h16, 8'h17, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_seq("wrap", exp_seq);

        // Backpressure
        got_q.delete();
        bus_if.rd_ready = 1'b0;
        hs0 = hs_count;
        request(0, 3);
        for (int i = 0; i < 7; i++) begin
            bus_if.rd_ready = bp_pat[i];
            tick();
        end
        bus_if.rd_ready = 1'b1;
        check("bp_handshakes", hs_count - hs0, 4);
        check("bp_done", {31'd0, m_active}, 32'd0);
        exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_seq("bp", exp_seq);

        // Request held during a running burst is accepted only after it ends
        got_q.delete();
        request(2, 3);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 3'd7;
        bus_if.req_len   = 3'd0;
        for (int i = 0; i < 5; i++) tick();
        bus_if.req_valid = 1'b0;
        wait_idle();
        exp_seq = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
        check_seq("ignored_req", exp_seq);

        // Asynchronous reset during beat 2
        request(0, 3);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        got_q.delete();
        request(1, 0);
        wait_idle();
        exp_seq = '{8'h11};
        check_seq("post_reset", exp_seq);

        // Randomized bursts with backpressure and request noise while streaming
        for (int b = 0; b < 40; b++) begin
            bus_if.req_valid = 1'b0;
            regs = {$urandom(), $urandom()};
            request($urandom_range(0, N - 1), $urandom_range(0, N - 1));
            n = 0;
            while (m_active && n < 300) begin
                bus_if.rd_ready  = ($urandom_range(0, 3) != 0);
                bus_if.req_valid = 1'($urandom);
                bus_if.req_addr  = AW'($urandom);
                bus_if.req_len   = AW'($urandom);
                tick();
                n++;
            end
            bus_if.req_valid = 1'b0;
            check("rand_timeout", {31'd0, m_active}, 32'd0);
        end
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
